pipe_addsub: RTL and testbench
==============================

Name: pipe_addsub

Overview:
- Parametrised successor to the team's 32-bit ripple-carry adder: N-bit add/subtract with carry-in.
- Carry chain is split into STAGES equal segments, with a register between each pair of segments, so the block closes timing at wide WIDTH.
- Valid/ready handshake on input and output, with full backpressure; drops straight into the ALU/datapath.
- Produces sum, carry-out, signed overflow and zero flags.

Parameters:
- WIDTH, 32, operand/result width in bits; must be divisible by STAGES.
- STAGES, 4, number of pipeline segments (1..WIDTH); each segment adds SEG = WIDTH/STAGES bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) or borrow-in (sub).
- sub  input  1  0: s = a + b + cin; 1: s = a - b - cin.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- s  output  WIDTH  result.
- cout  output  1  carry-out of bit WIDTH-1 (for sub: 1 = no borrow).
- ovf  output  1  signed two's-complement overflow.
- zero  output  1  s == 0.

Behaviour:
- Reset (rst_n=0 at clk edge): all stage valid bits cleared; out_valid=0, s=0, cout=0, ovf=0, zero=0. Any in-flight beats are discarded. in_ready=1 from the first cycle after reset.
- Operand prep, combinational at input:
  - bb = sub ? ~b : b.
  - c0 = sub ? ~cin : cin.
- Stage k (0..STAGES-1):
  - Computes bits [k*SEG +: SEG] of a + bb using the carry registered from stage k-1 (c0 for k=0).
  - Registers that partial sum, the carry out, and the still-unconsumed upper slices of a/bb (skew registers).
- Latency: exactly STAGES cycles from an accepted input beat (in_valid & in_ready) to out_valid=1 for that beat, given no stall.
- Throughput: one beat per cycle.
- Handshake:
  - in_ready = ~out_valid | out_ready. This is a global stall: when the output holds valid data and out_ready=0, every stage holds.
  - When stalled, s/cout/ovf/zero/out_valid stay stable until accepted.
  - Bubbles (in_valid=0 while in_ready=1) propagate as invalid stages and do not stall.
  - Simultaneous accept at the input and consume at the output in the same cycle is legal; occupancy is unchanged.
  - in_valid with in_ready=0: the beat is not taken, and upstream must hold it.
- Flags, computed in the final stage:
  - cout = carry out of the top segment.
  - ovf = (a[MSB] == bb[MSB]) & (s[MSB] != a[MSB]), using the operands as carried through the skew.
  - zero = ~|s.
- Wrap-around: results are modulo 2^WIDTH.
- STAGES=1 degenerates to a single registered adder with latency 1.
- STAGES=WIDTH gives 1-bit segments.

Optional Feature:
- Macro ADDSUB_SAT_EN.
- Defined:
  - When ovf=1, s is clamped to the signed extreme: the max positive value 0111..1 if a[MSB]=0, else the min negative value 1000..0.
  - ovf still reports 1.
  - zero is evaluated on the clamped value.
  - cout is unchanged.
  - The clamp is applied in the final stage, so latency is unchanged.
- Undefined: s wraps modulo 2^WIDTH, and no saturation logic is generated.

Test Plan:
- Add with carry chain across every segment boundary. Stimulus: reset low for 2 cycles, then a=32'hFFFF_FFFF, b=32'h0000_0001, cin=0, sub=0. Required: out_valid exactly 4 cycles after accept; s=0, cout=1, zero=1, ovf=0.
- Subtract, signed overflow. Stimulus: a=32'h8000_0000, b=1, sub=1, cin=0. Required: s=32'h7FFF_FFFF, cout=1, ovf=1. With ADDSUB_SAT_EN: s=32'h8000_0000, ovf=1.
- Subtract with borrow. Stimulus: a=5, b=7, sub=1, cin=1. Required: s=32'hFFFF_FFFD, cout=0, ovf=0.
- Back-to-back stream. Stimulus: 100 random beats, in_valid=1 continuously, out_ready=1. Required: one result per cycle, in order, each matching reference a±b±cin.
- Backpressure. Stimulus: out_ready=0 for 5 cycles while the pipeline is full. Required: in_ready=0, outputs held stable; on release no beat is lost or duplicated.
- Reset mid-operation. Stimulus: rst_n=0 for one cycle with 3 beats in flight. Required: out_valid=0 next cycle, those beats never appear, new beats complete with latency 4.

Source files
------------

// File: rtl/pipe_addsub.sv
// pipe_addsub: WIDTH-bit add/subtract with carry-in, carry chain split into STAGES registered segments, valid/ready handshake
// Ports: clk, rst_n (sync active-low); in_valid/in_ready, a, b, cin, sub (input beat);
//        out_valid/out_ready, s, cout, ovf, zero (result beat).
// Optional: define ADDSUB_SAT_EN to clamp s to the signed extreme on overflow.
module pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int SEG = WIDTH / STAGES;
  logic [WIDTH-1:0] bb;
  logic c0, en;
  assign bb = sub ? ~b : b;
  assign c0 = sub ? ~cin : cin;
  // Global stall: every stage advances only when the output slot is free or being taken.
  assign en = ~out_valid | out_ready;
  assign in_ready = en;
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] ai, bi, si, sn;
    logic ci, vi;
    logic [SEG:0] ps;
    if (k == 0) begin : g_in
      assign ai = a;
      assign bi = bb;
      assign si = '0;
      assign ci = c0;
      assign vi = in_valid;
    end else begin : g_chain
      assign ai = g_stage[k-1].g_mid.ar;
      assign bi = g_stage[k-1].g_mid.br;
      assign si = g_stage[k-1].g_mid.sr;
      assign ci = g_stage[k-1].g_mid.cr;
      assign vi = g_stage[k-1].g_mid.vr;
    end
    assign ps = {1'b0, ai[k*SEG +: SEG]} + {1'b0, bi[k*SEG +: SEG]} + {{SEG{1'b0}}, ci};
    always_comb begin
      sn = si;
      sn[k*SEG +: SEG] = ps[SEG-1:0];
    end
    if (k < STAGES - 1) begin : g_mid
      // Full operands ride along so later segments find their slices aligned in time.
      logic [WIDTH-1:0] ar, br, sr;
      logic cr, vr;
      always_ff @(posedge clk) begin
        if (!rst_n) vr <= 1'b0;
        else if (en) begin
          ar <= ai;
          br <= bi;
          sr <= sn;
          cr <= ps[SEG];
          vr <= vi;
        end
      end
    end else begin : g_last
      logic ov;
      logic [WIDTH-1:0] fs;
      logic unused_ops;
      assign ov = (ai[WIDTH-1] == bi[WIDTH-1]) & (sn[WIDTH-1] != ai[WIDTH-1]);
`ifdef ADDSUB_SAT_EN
      assign fs = ov ? {ai[WIDTH-1], {(WIDTH-1){~ai[WIDTH-1]}}} : sn;
`else
      assign fs = sn;
`endif
      // Only the top slice and sign bits of the skewed operands matter here.
      assign unused_ops = ^{ai, bi};
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          s         <= '0;
          cout      <= 1'b0;
          ovf       <= 1'b0;
          zero      <= 1'b0;
        end else if (en) begin
          out_valid <= vi;
          s         <= fs;
          cout      <= ps[SEG];
          ovf       <= ov;
          zero      <= ~|fs;
        end
      end
    end
  end
endmodule

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub: scoreboard bench for pipe_addsub (directed cases, random stream, backpressure, mid-run reset)
module tb_pipe_addsub;
  localparam int W = 32;
  localparam int ST = 4;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, cin = 1'b0, sub = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, cout, ovf, zero;
  logic [W-1:0] a = '0, b = '0, s;
  typedef struct {
    logic [W-1:0] s;
    logic cout, ovf, zero;
    int cyc;
    bit lat;
  } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0, cyc = 0;

  pipe_addsub #(.WIDTH(W), .STAGES(ST)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic sb);
    exp_t e;
    logic [W:0] wide;
    logic signed [W+1:0] r;
    if (!sb) begin
      wide = {1'b0, x} + {1'b0, y} + (W+1)'(c);
      e.cout = wide[W];
      r = (W+2)'($signed(x)) + (W+2)'($signed(y)) + (W+2)'(c);
    end else begin
      e.cout = ({1'b0, x} >= ({1'b0, y} + (W+1)'(c)));
      r = (W+2)'($signed(x)) - (W+2)'($signed(y)) - (W+2)'(c);
    end
    e.s = r[W-1:0];
    e.ovf = (r > 34'sd2147483647) || (r < -34'sd2147483648);
`ifdef ADDSUB_SAT_EN
    if (e.ovf) e.s = x[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    e.zero = (e.s == '0);
    e.cyc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      checks++;
      assert (q.size() > 0) else begin
        failures++;
        $error("FAIL spurious_out observed s=%0h expected no beat", s);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("s", s, e.s);
        chk("cout", W'(cout), W'(e.cout));
        chk("ovf", W'(ovf), W'(e.ovf));
        chk("zero", W'(zero), W'(e.zero));
        if (e.lat) chk("latency", W'(cyc - e.cyc), W'(ST));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic sb, input bit lat);
    exp_t e;
    int n = 0;
    in_valid = 1'b1;
    a = x;
    b = y;
    cin = c;
    sub = sb;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        e = model(x, y, c, sb);
        e.cyc = cyc;
        e.lat = lat;
        q.push_back(e);
        break;
      end
      tick();
      n++;
      if (n > 100) begin
        checks++;
        failures++;
        $error("FAIL accept_timeout observed in_ready=0 expected 1 within 100 cycles");
        break;
      end
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (q.size() > 0 || out_valid); i++) @(negedge clk);
    chk("drain_left", W'(q.size()), '0);
    tick();
  endtask

  initial begin
    logic [W+3:0] held;
    rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_s", s, '0);
    chk("rst_flags", W'({cout, ovf, zero}), '0);
    rst_n = 1'b1;
    chk("rst_in_ready", W'(in_ready), W'(1));
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1);
    send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b1);
    send(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    send(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
    drain();
    for (int i = 0; i < 100; i++)
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    drain();
    out_ready = 1'b0;
    for (int i = 0; i < ST; i++) send($urandom, $urandom, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    held = {out_valid, s, cout, ovf, zero};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", W'(in_ready), '0);
      chk("stall_hold_s", s, held[W+2:3]);
      chk("stall_hold_flags", W'({out_valid, cout, ovf, zero}), W'({held[W+3], held[2:0]}));
    end
    tick();
    out_ready = 1'b1;
    drain();
    for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    q.delete();
    tick();
    rst_n = 1'b1;
    chk("midrst_out_valid", W'(out_valid), '0);
    chk("midrst_in_ready", W'(in_ready), W'(1));
    repeat (6) @(negedge clk);
    tick();
    send(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 1'b1);
    send(32'h0000_0003, 32'h0000_0009, 1'b0, 1'b1, 1'b1);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
